bus_err_inject: RTL and testbench

- Fault-injection companion to the bus error monitor, on the response side of the same one-hot-channel handshake interface.
- Watches request handshakes and address-matches them against a configured window; tags matching transactions in per-channel in-order trackers.
- When a tagged transaction's response handshakes, overrides its error field with a configured error code.
- Exercises error-detection, IRQ and logging paths end-to-end.

---
 rtl/bus_err_inject_pkg.sv | 32 +++
 rtl/bus_err_inject_track.sv | 79 +++++++
 rtl/bus_err_inject.sv | 210 +++++++++++++++++++++
 tb/tb_bus_err_inject.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_err_inject_pkg.sv
// bus_err_inject_pkg
// Shared types and constants for the bus error injector:
//   - state_e  : campaign FSM states (IDLE / ARMED / DONE)
//   - entry_t  : per-transaction tracker entry {inject, code}
//   - LFSR seed/tap constants and a single-step helper for the optional
//     random-rate mode (BUS_ERR_INJECT_RANDOM_EN).
// The entry code field is sized to MaxErrBits so one struct serves any
// ErrBits up to that width; the top zero-extends on write and slices on read.
package bus_err_inject_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int unsigned MaxErrBits = 8;

  typedef struct packed {
    logic                  inject;
    logic [MaxErrBits-1:0] code;
  } entry_t;

  localparam logic [15:0] LfsrSeed = 16'hACE1;
  // Fibonacci taps 16,14,13,11 -> bit positions 15,13,12,10
  localparam logic [15:0] LfsrTaps = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LfsrTaps)};
  endfunction

endpackage

// File: rtl/bus_err_inject_track.sv
// bus_err_inject_track
// In-order tracker for one channel: a Depth-entry FIFO of entry_t.
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   push_i         : request handshake on this channel
//   push_entry_i   : {inject, code} captured at request time
//   pop_i          : last beat of a response on this channel
//   full_o/empty_o : occupancy flags
//   head_o         : oldest outstanding entry (valid when !empty_o)
// A push while full is accepted only if a pop happens in the same cycle;
// otherwise it is dropped (the top flags that as a protocol error).
module bus_err_inject_track
  import bus_err_inject_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   push_i,
  input  entry_t push_entry_i,
  input  logic   pop_i,
  output logic   full_o,
  output logic   empty_o,
  output entry_t head_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  entry_t [Depth-1:0] mem_q, mem_d;
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]      cnt_q, cnt_d;
  logic               push_ok_s, pop_ok_s;

  assign full_o  = (cnt_q == (PtrW+1)'(Depth));
  assign empty_o = (cnt_q == (PtrW+1)'(0));
  assign head_o  = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy
  always_comb begin
    pop_ok_s  = pop_i && !empty_o;
    push_ok_s = push_i && (!full_o || pop_ok_s);
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = push_entry_i;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   cnt_d = cnt_q + (PtrW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PtrW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Tracker state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '0;
      wr_ptr_q <= PtrW'(0);
      rd_ptr_q <= PtrW'(0);
      cnt_q    <= (PtrW+1)'(0);
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/bus_err_inject.sv
// bus_err_inject
// Response-side fault injector. Request handshakes inside the configured
// address window are tagged (while ARMED) in per-channel in-order trackers;
// when a tagged transaction's response arrives, every beat of it carries
// cfg_err_code (latched at request time) instead of the upstream code.
// Ports:
//   clk_i, rst_ni              : clock, asynchronous active-low reset
//   req_hs_valid_i/req_addr_i  : request handshake (one-hot) and address
//   req_stall_o                : per-channel tracker full
//   rsp_hs_valid_i/rsp_burst_last_i/rsp_err_i : response handshake
//   rsp_err_o                  : forwarded error code (combinational)
//   cfg_*                      : match window, code, count (0=unlimited), rate
//   arm_i/disarm_i             : campaign control pulses (disarm wins)
//   armed_o/done_o             : FSM state decode
//   proto_err_o                : sticky protocol violation (cleared by arm_i)
// Optional macro BUS_ERR_INJECT_RANDOM_EN adds a 16-bit LFSR gate: a
// matching request is tagged only when lfsr[7:0] < cfg_rate_i.
module bus_err_inject
  import bus_err_inject_pkg::*;
#(
  parameter int unsigned AddrWidth      = 48,
  parameter int unsigned ErrBits        = 3,
  parameter int unsigned NumOutstanding = 4,
  parameter int unsigned NumChannels    = 1,
  parameter int unsigned CntWidth       = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumChannels-1:0] req_hs_valid_i,
  input  logic [AddrWidth-1:0]   req_addr_i,
  output logic [NumChannels-1:0] req_stall_o,
  input  logic [NumChannels-1:0] rsp_hs_valid_i,
  input  logic [NumChannels-1:0] rsp_burst_last_i,
  input  logic [ErrBits-1:0]     rsp_err_i,
  output logic [ErrBits-1:0]     rsp_err_o,
  input  logic [AddrWidth-1:0]   cfg_addr_base_i,
  input  logic [AddrWidth-1:0]   cfg_addr_mask_i,
  input  logic [ErrBits-1:0]     cfg_err_code_i,
  input  logic [CntWidth-1:0]    cfg_count_i,
  input  logic [7:0]             cfg_rate_i,
  input  logic                   arm_i,
  input  logic                   disarm_i,
  output logic                   armed_o,
  output logic                   done_o,
  output logic                   proto_err_o
);

  state_e                state_q, state_d;
  logic [CntWidth-1:0]   remaining_q, remaining_d;
  logic                  proto_q, proto_d;

  logic [NumChannels-1:0] req_sel_s, rsp_sel_s, pop_vec_s, full_vec_s, empty_vec_s;
  entry_t                 head_vec_s [NumChannels];
  entry_t                 rsp_head_s, push_entry_s;
  logic req_any_s, rsp_any_s, req_multi_s, rsp_multi_s;
  logic match_s, rate_ok_s, tag_s, drop_s, tag_acc_s, rsp_empty_s, violation_s;

  // Isolate the lowest set valid bit; extra bits are a protocol violation.
  assign req_sel_s   = req_hs_valid_i & (~req_hs_valid_i + NumChannels'(1));
  assign rsp_sel_s   = rsp_hs_valid_i & (~rsp_hs_valid_i + NumChannels'(1));
  assign req_any_s   = |req_hs_valid_i;
  assign rsp_any_s   = |rsp_hs_valid_i;
  assign req_multi_s = (req_hs_valid_i & (req_hs_valid_i - NumChannels'(1))) != {NumChannels{1'b0}};
  assign rsp_multi_s = (rsp_hs_valid_i & (rsp_hs_valid_i - NumChannels'(1))) != {NumChannels{1'b0}};
  assign pop_vec_s   = rsp_sel_s & rsp_burst_last_i;

  assign match_s = ((req_addr_i ^ cfg_addr_base_i) & cfg_addr_mask_i) == {AddrWidth{1'b0}};

`ifdef BUS_ERR_INJECT_RANDOM_EN
  logic [15:0] lfsr_q, lfsr_d;

  // LFSR advances once per request handshake
  always_comb begin
    if (req_any_s) begin
      lfsr_d = lfsr_step(lfsr_q);
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  // LFSR register; seed is non-zero so the sequence never locks up
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= LfsrSeed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign rate_ok_s = (lfsr_q[7:0] < cfg_rate_i);
`else
  logic unused_rate_s;
  assign unused_rate_s = ^cfg_rate_i;
  assign rate_ok_s     = 1'b1;
`endif

  assign tag_s     = req_any_s && match_s && (state_q == ST_ARMED) && rate_ok_s;
  // A push to a full tracker is only dropped when no pop frees a slot
  assign drop_s    = |(req_sel_s & full_vec_s & ~pop_vec_s);
  assign tag_acc_s = tag_s && !drop_s;

  assign push_entry_s = '{inject: tag_s, code: MaxErrBits'(cfg_err_code_i)};

  for (genvar g = 0; g < NumChannels; g++) begin : g_track
    bus_err_inject_track #(
      .Depth(NumOutstanding)
    ) u_track (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .push_i      (req_sel_s[g]),
      .push_entry_i(push_entry_s),
      .pop_i       (pop_vec_s[g]),
      .full_o      (full_vec_s[g]),
      .empty_o     (empty_vec_s[g]),
      .head_o      (head_vec_s[g])
    );
  end

  // Head of the tracker belonging to the active response channel
  always_comb begin
    rsp_head_s = '0;
    for (int c = 0; c < NumChannels; c++) begin
      rsp_head_s = rsp_head_s | (head_vec_s[c] & {($bits(entry_t)){rsp_sel_s[c]}});
    end
  end

  assign rsp_empty_s = |(rsp_sel_s & empty_vec_s);

  logic unused_head_s;
  assign unused_head_s = ^rsp_head_s.code;

  // Zero-latency override: tagged head replaces the code on every beat
  always_comb begin
    if (rsp_any_s && !rsp_empty_s && rsp_head_s.inject) begin
      rsp_err_o = rsp_head_s.code[ErrBits-1:0];
    end else begin
      rsp_err_o = rsp_err_i;
    end
  end

  // Campaign FSM and remaining-injection counter
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    if (disarm_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (arm_i) begin
            state_d     = ST_ARMED;
            remaining_d = cfg_count_i;
          end else begin
            state_d = state_q;
          end
        end
        ST_ARMED: begin
          if (tag_acc_s && (cfg_count_i != {CntWidth{1'b0}}) &&
              (remaining_q != {CntWidth{1'b0}})) begin
            remaining_d = remaining_q - CntWidth'(1);
            if (remaining_q == CntWidth'(1)) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_ARMED;
            end
          end else begin
            state_d = ST_ARMED;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign violation_s = req_multi_s || rsp_multi_s || drop_s || (rsp_any_s && rsp_empty_s);

  // Sticky protocol flag: arm clears it, a same-cycle violation still sets it
  always_comb begin
    proto_d = proto_q;
    if (arm_i) begin
      proto_d = 1'b0;
    end else begin
      proto_d = proto_q;
    end
    if (violation_s) begin
      proto_d = 1'b1;
    end else begin
      proto_d = proto_d;
    end
  end

  // Control registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      remaining_q <= CntWidth'(0);
      proto_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      proto_q     <= proto_d;
    end
  end

  assign armed_o     = (state_q == ST_ARMED);
  assign done_o      = (state_q == ST_DONE);
  assign proto_err_o = proto_q;
  assign req_stall_o = full_vec_s;

endmodule

// File: tb/tb_bus_err_inject.sv
module tb_bus_err_inject;
  localparam int AW = 48, EB = 3, NO = 4, NCH = 1, CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_ni = 1'b0;
  logic [NCH-1:0] req_v = '0, rsp_v = '0, rsp_last = '0, stall;
  logic [AW-1:0]  req_addr = '0, cfg_base = '0, cfg_mask = '0;
  logic [EB-1:0]  rsp_err = '0, cfg_code = '0, rsp_err_out;
  logic [CW-1:0]  cfg_count = '0;
  logic [7:0]     cfg_rate = 8'd255;
  logic           arm = 1'b0, disarm = 1'b0, armed, done, proto;

  bus_err_inject dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_hs_valid_i(req_v), .req_addr_i(req_addr), .req_stall_o(stall),
    .rsp_hs_valid_i(rsp_v), .rsp_burst_last_i(rsp_last), .rsp_err_i(rsp_err),
    .rsp_err_o(rsp_err_out),
    .cfg_addr_base_i(cfg_base), .cfg_addr_mask_i(cfg_mask),
    .cfg_err_code_i(cfg_code), .cfg_count_i(cfg_count), .cfg_rate_i(cfg_rate),
    .arm_i(arm), .disarm_i(disarm),
    .armed_o(armed), .done_o(done), .proto_err_o(proto)
  );

  int checks = 0, errors = 0;

  // ---------------- behavioural reference model ----------------
  typedef struct packed { logic inj; logic [EB-1:0] code; } ment_t;
  ment_t       mq [NCH][$];
  int          mode = 0;        // 0 idle, 1 armed, 2 done
  int          rem = 0;
  bit          mproto = 1'b0;
  logic [15:0] lfsr = 16'hACE1;

  function automatic int lowest(logic [NCH-1:0] v);
    for (int i = 0; i < NCH; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int popcnt(logic [NCH-1:0] v);
    int n = 0;
    for (int i = 0; i < NCH; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic bit rate_ok();
`ifdef BUS_ERR_INJECT_RANDOM_EN
    return lfsr[7:0] < cfg_rate;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [EB-1:0] exp_rsp();
    int sc = lowest(rsp_v);
    if (sc >= 0 && mq[sc].size() > 0 && mq[sc][0].inj) return mq[sc][0].code;
    return rsp_err;
  endfunction

  task automatic model_step();
    int  rc, sc;
    bit  viol, do_pop, tag, acc;
    if (!rst_ni) begin
      mode = 0; rem = 0; mproto = 1'b0; lfsr = 16'hACE1;
      for (int c = 0; c < NCH; c++) mq[c].delete();
      return;
    end
    rc = lowest(req_v); sc = lowest(rsp_v);
    viol = (popcnt(req_v) > 1) || (popcnt(rsp_v) > 1);
    do_pop = 1'b0; tag = 1'b0; acc = 1'b0;
    if (sc >= 0) begin
      if (mq[sc].size() == 0) viol = 1'b1;
      else if (rsp_last[sc]) do_pop = 1'b1;
    end
    if (do_pop) void'(mq[sc].pop_front());
    if (rc >= 0) begin
      tag = (mode == 1) && (((req_addr ^ cfg_base) & cfg_mask) == '0) && rate_ok();
      if (mq[rc].size() < NO) begin
        acc = 1'b1;
        mq[rc].push_back('{inj: tag, code: cfg_code});
      end else viol = 1'b1;
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
    if (arm) mproto = 1'b0;
    if (viol) mproto = 1'b1;
    if (disarm) mode = 0;
    else if (mode == 1) begin
      if (tag && acc && cfg_count != '0 && rem > 0) begin
        rem--;
        if (rem == 0) mode = 2;
      end
    end else if (arm) begin
      mode = 1; rem = int'(cfg_count);
    end
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // one clock: model follows the edge, inputs may change 1 time unit later
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_req(logic v, logic [AW-1:0] a);
    req_v = NCH'(v); req_addr = a;
  endtask

  task automatic set_rsp(logic v, logic l, logic [EB-1:0] e);
    rsp_v = NCH'(v); rsp_last = NCH'(l); rsp_err = e;
  endtask

  // continuous compare of every output against the model, mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      chk("armed_o", armed, (mode == 1));
      chk("done_o", done, (mode == 2));
      chk("proto_err_o", proto, mproto);
      for (int c = 0; c < NCH; c++) chk("req_stall_o", stall[c], (mq[c].size() == NO));
      chk("rsp_err_o", rsp_err_out, exp_rsp());
    end
  end

  initial begin
    int inj;
    logic [AW-1:0] addrs [4];
    addrs[0] = 48'h1004; addrs[1] = 48'h2000; addrs[2] = 48'h1008; addrs[3] = 48'h100C;

    // reset
    tick(); tick();
    chk("rst_armed", armed, 1'b0); chk("rst_done", done, 1'b0);
    chk("rst_proto", proto, 1'b0); chk("rst_stall", stall, 1'b0);
    rst_ni = 1'b1;
    tick();

    // count mode
    cfg_base = 48'h1000; cfg_mask = ~48'hFFF; cfg_code = 3'd3; cfg_count = 16'd2;
    arm = 1'b1; tick(); arm = 1'b0;
    chk("cnt_armed", armed, 1'b1);
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, addrs[i]); tick();
      if (i == 1) chk("cnt_done_early", done, 1'b0);
      if (i == 2) chk("cnt_done", done, 1'b1);
    end
    set_req(1'b0, '0);
    chk("cnt_full", stall, 1'b1);
    for (int i = 0; i < 4; i++) begin
      set_rsp(1'b1, 1'b1, 3'd0); #2;
      chk("cnt_rsp", rsp_err_out, (i == 0 || i == 2) ? 3'd3 : 3'd0);
      tick();
    end
    set_rsp(1'b0, 1'b0, 3'd0);

    // burst override
    arm = 1'b1; tick(); arm = 1'b0;
    set_req(1'b1, 48'h1010); tick();
    set_req(1'b1, 48'h5000); tick();
    set_req(1'b0, '0);
    for (int b = 0; b < 4; b++) begin
      set_rsp(1'b1, (b == 3), 3'd0); #2;
      chk("burst_beat", rsp_err_out, 3'd3);
      tick();
    end
    set_rsp(1'b1, 1'b1, 3'd5); #2;
    chk("burst_next_pass", rsp_err_out, 3'd5);
    tick();
    set_rsp(1'b0, 1'b0, 3'd0);

    // full tracker
    disarm = 1'b1; tick(); disarm = 1'b0;
    for (int i = 0; i < 4; i++) begin set_req(1'b1, 48'h1000); tick(); end
    chk("full_stall", stall, 1'b1);
    set_rsp(1'b1, 1'b1, 3'd0); tick();
    set_rsp(1'b0, 1'b0, 3'd0);
    chk("full_pushpop_stall", stall, 1'b1); chk("full_pushpop_proto", proto, 1'b0);
    tick();
    set_req(1'b0, '0);
    chk("full_drop_proto", proto, 1'b1);
    for (int i = 0; i < 4; i++) begin set_rsp(1'b1, 1'b1, 3'd1); tick(); end
    set_rsp(1'b0, 1'b0, 3'd0);
    chk("full_drained", stall, 1'b0);

    // response on empty tracker
    arm = 1'b1; tick(); arm = 1'b0;
    chk("arm_clears_proto", proto, 1'b0);
    disarm = 1'b1; tick(); disarm = 1'b0;
    set_rsp(1'b1, 1'b1, 3'd2); #2;
    chk("empty_pass", rsp_err_out, 3'd2);
    tick();
    set_rsp(1'b0, 1'b0, 3'd0);
    chk("empty_proto", proto, 1'b1);
    arm = 1'b1; tick(); arm = 1'b0;
    chk("rearm_clears_proto", proto, 1'b0);
    disarm = 1'b1; tick(); disarm = 1'b0;

    // disarm priority and mid-campaign disarm
    arm = 1'b1; disarm = 1'b1; tick(); arm = 1'b0; disarm = 1'b0;
    chk("disarm_priority", armed, 1'b0);
    cfg_code = 3'd6; cfg_count = 16'd0;
    arm = 1'b1; tick(); arm = 1'b0;
    set_req(1'b1, 48'h1ABC); tick(); tick();
    set_req(1'b0, '0);
    disarm = 1'b1; tick(); disarm = 1'b0;
    set_req(1'b1, 48'h1ABC); tick();
    set_req(1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      set_rsp(1'b1, 1'b1, 3'd0); #2;
      chk("disarm_rsp", rsp_err_out, (i < 2) ? 3'd6 : 3'd0);
      tick();
    end
    set_rsp(1'b0, 1'b0, 3'd0);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) begin
        cfg_code = EB'($urandom_range(0, 7));
        cfg_count = CW'($urandom_range(0, 3));
        cfg_rate = 8'($urandom_range(0, 255));
      end
      case ($urandom_range(0, 3))
        0: req_addr = 48'h1000 | AW'($urandom_range(0, 4095));
        1: req_addr = 48'h2000 | AW'($urandom_range(0, 4095));
        2: req_addr = AW'({$urandom(), $urandom()});
        default: req_addr = cfg_base;
      endcase
      req_v = NCH'($urandom_range(0, 99) < 40);
      set_rsp($urandom_range(0, 99) < 35, $urandom_range(0, 99) < 60, EB'($urandom_range(0, 7)));
      arm = ($urandom_range(0, 99) < 3);
      disarm = ($urandom_range(0, 99) < 2);
      tick();
    end
    set_req(1'b0, '0); arm = 1'b0; disarm = 1'b1; tick(); disarm = 1'b0;
    for (int k = 0; k < NO * NCH + 2; k++) begin
      set_rsp(mq[0].size() > 0, 1'b1, 3'd0); tick();
    end
    set_rsp(1'b0, 1'b0, 3'd0);

`ifdef BUS_ERR_INJECT_RANDOM_EN
    cfg_code = 3'd3; cfg_count = 16'd0; cfg_rate = 8'd0;
    arm = 1'b1; tick(); arm = 1'b0;
    for (int r = 0; r < 2; r++) begin
      inj = 0;
      for (int i = 0; i < 100; i++) begin
        set_req(1'b1, 48'h1000); tick(); set_req(1'b0, '0);
        set_rsp(1'b1, 1'b1, 3'd0); #2;
        if (rsp_err_out == 3'd3) inj++;
        tick(); set_rsp(1'b0, 1'b0, 3'd0);
      end
      if (r == 0) chk("rate0_injections", inj, 0);
      else chk("rate255_injections", (inj >= 99), 1'b1);
      cfg_rate = 8'd255;
    end
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
